// File: rtl/lane_decoder.sv
// Reassembles bit-inverted three-lane frames from a narrow beat stream and
// presents one decoded frame per valid/ready transfer, counting framing errors.
module lane_decoder #(
    parameter int unsigned P1   = 4,
    parameter int unsigned P2   = 5,
    parameter int unsigned IN_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IN_W-1:0] in_data,
    input  logic            in_valid,
    input  logic            in_last,
    output logic            in_ready,
    output logic [P1-1:0]   out1,
    output logic [P2-1:0]   out2,
    output logic [3:0]      out3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            err,
    output logic [7:0]      err_cnt
);

    localparam int unsigned TOT   = P1 + P2 + 4;
    localparam int unsigned BEATS = (TOT + IN_W - 1) / IN_W;
    localparam int unsigned ACC_W = (BEATS - 1) * IN_W;
    localparam int unsigned CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [P1-1:0]    out1_q, out1_d;
    logic [P2-1:0]    out2_q, out2_d;
    logic [3:0]       out3_q, out3_d;
    logic             out_valid_q, out_valid_d;
    logic             err_q, err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic             is_last_c;
    logic             accept_c;
    logic [TOT-1:0]   frame_c;

    // Final beat is never stored: the frame is formed from the accumulator plus the live beat.
    assign is_last_c = (beat_cnt_q == LAST_BEAT);
    assign in_ready  = !is_last_c || !out_valid_q || out_ready;
    assign accept_c  = in_valid && in_ready;
    assign frame_c   = TOT'({in_data, acc_q});

    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        acc_d       = acc_q;
        out1_d      = out1_q;
        out2_d      = out2_q;
        out3_d      = out3_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept_c) begin
            // in_last must coincide exactly with the final beat slot
            if (is_last_c != in_last) begin
                beat_cnt_d = '0;
                err_d      = 1'b1;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end else if (is_last_c) begin
                out1_d      = ~frame_c[P1-1:0];
                out2_d      = ~frame_c[P1+P2-1:P1];
                out3_d      = frame_c[TOT-1:P1+P2];
                out_valid_d = 1'b1;
                beat_cnt_d  = '0;
            end else begin
                for (int unsigned k = 0; k < BEATS - 1; k++) begin
                    if (beat_cnt_q == CNT_W'(k)) begin
                        acc_d[k*IN_W +: IN_W] = in_data;
                    end
                end
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q  <= '0;
            acc_q       <= '0;
            out1_q      <= '0;
            out2_q      <= '0;
            out3_q      <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            acc_q       <= acc_d;
            out1_q      <= out1_d;
            out2_q      <= out2_d;
            out3_q      <= out3_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out1      = out1_q;
    assign out2      = out2_q;
    assign out3      = out3_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_lane_decoder.sv
// Directed bench for lane_decoder: vector table of whole frames plus
// hand-written backpressure, framing-error, saturation and reset sequences.
module tb_lane_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [3:0] out1;
    logic [4:0] out2;
    logic [3:0] out3;
    logic       out_valid;
    logic       out_ready;
    logic       err;
    logic [7:0] err_cnt;

    int total = 0;
    int bad   = 0;

    lane_decoder #(.P1(4), .P2(5), .IN_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] beats;   // beat k at [4k +: 4]
        logic [3:0]  e1;
        logic [4:0]  e2;
        logic [3:0]  e3;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic beat(input logic [3:0] d, input logic l);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 20) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: in_ready stuck at 0 at %0t", $time);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input logic [15:0] f);
        for (int b = 0; b < 4; b++) beat(f[b*4 +: 4], b == 3);
    endtask

    task automatic chk_frame(input string nm, input logic [3:0] e1, input logic [4:0] e2,
                             input logic [3:0] e3);
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_out1"}, 32'(out1), 32'(e1));
        chk({nm, "_out2"}, 32'(out2), 32'(e2));
        chk({nm, "_out3"}, 32'(out3), 32'(e3));
        chk({nm, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0] = '{16'h0D3A, 4'h5, 5'h0C, 4'h6};
        vecs[1] = '{16'h0000, 4'hF, 5'h1F, 4'h0};
        vecs[2] = '{16'h1FFF, 4'h0, 5'h00, 4'hF};
        vecs[3] = '{16'h0123, 4'hC, 5'h0D, 4'h0};
        vecs[4] = '{16'h1A5C, 4'h3, 5'h1A, 4'hD};
        vecs[5] = '{16'hE000, 4'hF, 5'h1F, 4'h0};  // padding bits set

        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_out1", 32'(out1), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // table: single frames with idle gap
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].beats);
            chk_frame($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2, vecs[i].e3);
            idle();
            chk($sformatf("vec%0d_drain", i), 32'(out_valid), 32'd0);
        end

        // back-to-back frames, no bubbles
        for (int f = 0; f < 3; f++) begin
            int vi;
            vi = (f == 0) ? 0 : (f == 1) ? 3 : 4;
            for (int b = 0; b < 4; b++) begin
                in_valid = 1'b1;
                in_data  = vecs[vi].beats[b*4 +: 4];
                in_last  = (b == 3);
                chk("b2b_in_ready", 32'(in_ready), 32'd1);
                @(posedge clk); #1;
                if (b == 3) chk_frame("b2b", vecs[vi].e1, vecs[vi].e2, vecs[vi].e3);
                else chk("b2b_gap", 32'(out_valid), 32'd0);
            end
        end
        idle();

        // backpressure: frame 2 waits on its last beat while frame 1 is held
        out_ready = 1'b0;
        send_frame(vecs[0].beats);
        chk_frame("bp_f1", 4'h5, 5'h0C, 4'h6);
        beat(4'h3, 1'b0);
        beat(4'h2, 1'b0);
        beat(4'h1, 1'b0);
        in_valid = 1'b1; in_data = 4'h0; in_last = 1'b1;
        chk("bp_stall_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("bp_stall_ready2", 32'(in_ready), 32'd0);
        chk_frame("bp_hold", 4'h5, 5'h0C, 4'h6);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        chk_frame("bp_f2", 4'hC, 5'h0D, 4'h0);
        idle();
        chk("bp_drain", 32'(out_valid), 32'd0);

        // early last on beat 1
        beat(4'hA, 1'b0);
        beat(4'h3, 1'b1);
        chk("early_err", 32'(err), 32'd1);
        chk("early_cnt", 32'(err_cnt), 32'd1);
        chk("early_valid", 32'(out_valid), 32'd0);
        idle();
        chk("early_err_pulse", 32'(err), 32'd0);
        send_frame(vecs[4].beats);
        chk_frame("after_err", 4'h3, 5'h1A, 4'hD);
        idle();

        // missing last on beat 3
        for (int b = 0; b < 4; b++) beat(vecs[0].beats[b*4 +: 4], 1'b0);
        chk("miss_err", 32'(err), 32'd1);
        chk("miss_cnt", 32'(err_cnt), 32'd2);
        chk("miss_valid", 32'(out_valid), 32'd0);
        idle();

        // saturation: every beat with in_last at slot 0 is an early last
        in_valid = 1'b1; in_last = 1'b1; in_data = 4'h5;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
        end
        chk("sat_cnt", 32'(err_cnt), 32'd255);
        @(posedge clk); #1;
        chk("sat_hold", 32'(err_cnt), 32'd255);
        chk("sat_err", 32'(err), 32'd1);
        idle();

        // mid-frame reset with a held output
        out_ready = 1'b0;
        send_frame(vecs[0].beats);
        beat(4'hA, 1'b0);
        beat(4'h3, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_out1", 32'(out1), 32'd0);
        chk("mrst_out2", 32'(out2), 32'd0);
        chk("mrst_out3", 32'(out3), 32'd0);
        chk("mrst_err_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        send_frame(vecs[1].beats);
        chk_frame("mrst_frame", 4'hF, 5'h1F, 4'h0);
        chk("mrst_cnt_after", 32'(err_cnt), 32'd0);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
